// File: rtl/inst_ascii_encoder_pkg.sv
// inst_ascii_encoder_pkg
// Shared definitions for the ASCII-to-MIPS line assembler.
// - FSM state and operand-class encodings.
// - MIPS opcode/funct values.
// - 40-bit right-aligned mnemonic constants, laid out like Verilog string literals.
// - Helpers: per-class operand count, slot kind, and field packing.
package inst_ascii_encoder_pkg;

  typedef enum logic [1:0] {
    ST_MNEM  = 2'd0,
    ST_OPS   = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_R3  = 3'd0,
    CLS_SH  = 3'd1,
    CLS_I   = 3'd2,
    CLS_LUI = 3'd3,
    CLS_MEM = 3'd4,
    CLS_JR  = 3'd5,
    CLS_NOP = 3'd6
  } cls_e;

  typedef struct packed {
    logic       hit;
    cls_e       cls;
    logic [5:0] opc;
    logic [5:0] fn;
  } lut_t;

  // Control characters recognised by the line parser.
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // Funct codes (SPECIAL opcode)
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Mnemonics as right-aligned ASCII, identical to the matching string literal.
  localparam logic [39:0] M_ADD   = 40'h0000414444;
  localparam logic [39:0] M_ADDU  = 40'h0041444455;
  localparam logic [39:0] M_SUB   = 40'h0000535542;
  localparam logic [39:0] M_SUBU  = 40'h0053554255;
  localparam logic [39:0] M_AND   = 40'h0000414E44;
  localparam logic [39:0] M_OR    = 40'h0000004F52;
  localparam logic [39:0] M_XOR   = 40'h0000584F52;
  localparam logic [39:0] M_NOR   = 40'h00004E4F52;
  localparam logic [39:0] M_SLT   = 40'h0000534C54;
  localparam logic [39:0] M_SLTU  = 40'h00534C5455;
  localparam logic [39:0] M_SLL   = 40'h0000534C4C;
  localparam logic [39:0] M_SRL   = 40'h000053524C;
  localparam logic [39:0] M_SRA   = 40'h0000535241;
  localparam logic [39:0] M_ADDI  = 40'h0041444449;
  localparam logic [39:0] M_ADDIU = 40'h4144444955;
  localparam logic [39:0] M_ANDI  = 40'h00414E4449;
  localparam logic [39:0] M_ORI   = 40'h00004F5249;
  localparam logic [39:0] M_XORI  = 40'h00584F5249;
  localparam logic [39:0] M_SLTI  = 40'h00534C5449;
  localparam logic [39:0] M_SLTIU = 40'h534C544955;
  localparam logic [39:0] M_LUI   = 40'h00004C5549;
  localparam logic [39:0] M_LB    = 40'h0000004C42;
  localparam logic [39:0] M_LBU   = 40'h00004C4255;
  localparam logic [39:0] M_LH    = 40'h0000004C48;
  localparam logic [39:0] M_LHU   = 40'h00004C4855;
  localparam logic [39:0] M_LW    = 40'h0000004C57;
  localparam logic [39:0] M_SB    = 40'h0000005342;
  localparam logic [39:0] M_SH    = 40'h0000005348;
  localparam logic [39:0] M_SW    = 40'h0000005357;
  localparam logic [39:0] M_JR    = 40'h0000004A52;
  localparam logic [39:0] M_NOP   = 40'h00004E4F50;

  // Number of comma-separated operands a class expects.
  function automatic logic [1:0] cls_count(input cls_e c);
    case (c)
      CLS_R3, CLS_SH, CLS_I, CLS_MEM: cls_count = 2'd3;
      CLS_LUI:                        cls_count = 2'd2;
      CLS_JR:                         cls_count = 2'd1;
      default:                        cls_count = 2'd0;
    endcase
  endfunction

  // Slot holds a hex immediate (otherwise a decimal register or shift amount).
  function automatic logic slot_is_imm(input cls_e c, input logic [1:0] idx);
    slot_is_imm = (((c == CLS_I) || (c == CLS_MEM)) && (idx == 2'd2)) ||
                  ((c == CLS_LUI) && (idx == 2'd1));
  endfunction

  // Pack operand slots into instruction fields. Slot 0 is always a register.
  function automatic logic [31:0] encode(input cls_e c, input logic [5:0] opc,
                                         input logic [5:0] fn, input logic [4:0] a,
                                         input logic [15:0] b, input logic [15:0] d);
    case (c)
      CLS_R3:         encode = {opc, b[4:0], d[4:0], a, 5'd0, fn};
      CLS_SH:         encode = {opc, 5'd0, b[4:0], a, d[4:0], fn};
      CLS_I, CLS_MEM: encode = {opc, b[4:0], a, d};
      CLS_LUI:        encode = {opc, 5'd0, a, b};
      CLS_JR:         encode = {opc, a, 15'd0, fn};
      default:        encode = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst_ascii_encoder_mnem_lut.sv
// inst_ascii_encoder_mnem_lut (asm_mnem_lut)
// Combinational mnemonic decoder.
//   mnem  in 40 : right-aligned uppercase mnemonic
//   entry out   : {hit, class, opcode, funct}; hit=0 for unknown mnemonics
module inst_ascii_encoder_mnem_lut
  import inst_ascii_encoder_pkg::*;
(
  input  logic [39:0] mnem,
  output lut_t        entry
);

  // Mnemonic table lookup
  always_comb begin
    entry = '{1'b0, CLS_NOP, 6'h00, 6'h00};
    case (mnem)
      M_ADD:   entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_ADD};
      M_ADDU:  entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_ADDU};
      M_SUB:   entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_SUB};
      M_SUBU:  entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_SUBU};
      M_AND:   entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_AND};
      M_OR:    entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_OR};
      M_XOR:   entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_XOR};
      M_NOR:   entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_NOR};
      M_SLT:   entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_SLT};
      M_SLTU:  entry = '{1'b1, CLS_R3,  OP_SPECIAL, FN_SLTU};
      M_SLL:   entry = '{1'b1, CLS_SH,  OP_SPECIAL, FN_SLL};
      M_SRL:   entry = '{1'b1, CLS_SH,  OP_SPECIAL, FN_SRL};
      M_SRA:   entry = '{1'b1, CLS_SH,  OP_SPECIAL, FN_SRA};
      M_ADDI:  entry = '{1'b1, CLS_I,   OP_ADDI,    6'h00};
      M_ADDIU: entry = '{1'b1, CLS_I,   OP_ADDIU,   6'h00};
      M_ANDI:  entry = '{1'b1, CLS_I,   OP_ANDI,    6'h00};
      M_ORI:   entry = '{1'b1, CLS_I,   OP_ORI,     6'h00};
      M_XORI:  entry = '{1'b1, CLS_I,   OP_XORI,    6'h00};
      M_SLTI:  entry = '{1'b1, CLS_I,   OP_SLTI,    6'h00};
      M_SLTIU: entry = '{1'b1, CLS_I,   OP_SLTIU,   6'h00};
      M_LUI:   entry = '{1'b1, CLS_LUI, OP_LUI,     6'h00};
      M_LB:    entry = '{1'b1, CLS_MEM, OP_LB,      6'h00};
      M_LBU:   entry = '{1'b1, CLS_MEM, OP_LBU,     6'h00};
      M_LH:    entry = '{1'b1, CLS_MEM, OP_LH,      6'h00};
      M_LHU:   entry = '{1'b1, CLS_MEM, OP_LHU,     6'h00};
      M_LW:    entry = '{1'b1, CLS_MEM, OP_LW,      6'h00};
      M_SB:    entry = '{1'b1, CLS_MEM, OP_SB,      6'h00};
      M_SH:    entry = '{1'b1, CLS_MEM, OP_SH,      6'h00};
      M_SW:    entry = '{1'b1, CLS_MEM, OP_SW,      6'h00};
      M_JR:    entry = '{1'b1, CLS_JR,  OP_SPECIAL, FN_JR};
      M_NOP:   entry = '{1'b1, CLS_NOP, OP_SPECIAL, 6'h00};
      default: entry = '{1'b0, CLS_NOP, 6'h00, 6'h00};
    endcase
  end

endmodule

// File: rtl/inst_ascii_encoder.sv
// inst_ascii_encoder
// Assembles one MIPS instruction per ASCII line into a 32-bit word.
//   clk, resetn         : clock, async active-low reset
//   in_valid/in_char    : character stream, accepted when in_ready=1
//   in_ready            : high in MNEM, OPS and DRAIN, low while a result is pending
//   out_valid/out_ready : result handshake; instr/err held while stalled
//   instr               : encoded word (0 when err=1)
//   err                 : line rejected
module inst_ascii_encoder
  import inst_ascii_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err
);

  state_e      state_r, state_s;
  logic [39:0] acc_r, acc_s;
  logic [2:0]  mlen_r, mlen_s;
  cls_e        cls_r, cls_s;
  logic [5:0]  opc_r, opc_s, fn_r, fn_s;
  logic [15:0] opv_r, opv_s;
  logic [2:0]  ocnt_r, ocnt_s;
  logic        odol_r, odol_s;
  logic [1:0]  idx_r, idx_s;
  logic [4:0]  op0_r, op0_s, st0_s;
  logic [15:0] op1_r, op1_s, st1_s;
  logic [15:0] op2_r, op2_s, st2_s;
  logic [31:0] instr_r, instr_s;
  logic        err_r, err_s;
  logic        out_valid_r, in_ready_r;

  logic [7:0]  ch_s;
  logic        is_letter_s, is_digit_s, is_hexl_s;
  logic [3:0]  nib_s;
  logic [15:0] reg_val_s;
  logic        accept_s, slot_imm_s, bad_s, done_s;
  logic [1:0]  cnt_s;
  lut_t        lut_s;

  inst_ascii_encoder_mnem_lut u_asm_mnem_lut (
    .mnem  (acc_r),
    .entry (lut_s)
  );

  assign ch_s        = ((in_char >= 8'h61) && (in_char <= 8'h7A)) ? (in_char - 8'h20) : in_char;
  assign is_letter_s = (ch_s >= 8'h41) && (ch_s <= 8'h5A);
  assign is_digit_s  = (ch_s >= 8'h30) && (ch_s <= 8'h39);
  assign is_hexl_s   = (ch_s >= 8'h41) && (ch_s <= 8'h46);
  assign nib_s       = is_digit_s ? ch_s[3:0] : (ch_s[3:0] + 4'd9);
  // Register/sa accumulator stays <= 31, so *10 never overflows 16 bits.
  assign reg_val_s   = (opv_r * 16'd10) + {12'd0, nib_s};
  assign accept_s    = in_valid && in_ready_r;
  assign slot_imm_s  = slot_is_imm(cls_r, idx_r);
  assign cnt_s       = cls_count(cls_r);

  // Current operand merged into its slot, used both on comma and on LF.
  assign st0_s = (idx_r == 2'd0) ? opv_r[4:0] : op0_r;
  assign st1_s = (idx_r == 2'd1) ? opv_r      : op1_r;
  assign st2_s = (idx_r == 2'd2) ? opv_r      : op2_r;

  // Next-state, accumulator and result computation, one character per cycle.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    mlen_s  = mlen_r;
    cls_s   = cls_r;
    opc_s   = opc_r;
    fn_s    = fn_r;
    opv_s   = opv_r;
    ocnt_s  = ocnt_r;
    odol_s  = odol_r;
    idx_s   = idx_r;
    op0_s   = op0_r;
    op1_s   = op1_r;
    op2_s   = op2_r;
    instr_s = instr_r;
    err_s   = err_r;
    bad_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_MNEM: begin
        if (accept_s && (ch_s != CH_CR)) begin
          if (is_letter_s) begin
            if (mlen_r == 3'd5) begin
              bad_s = 1'b1;
            end else begin
              acc_s  = {acc_r[31:0], ch_s};
              mlen_s = mlen_r + 3'd1;
            end
          end else if (ch_s == CH_SP) begin
            if (mlen_r == 3'd0) begin
              state_s = ST_MNEM;            // leading space
            end else if (lut_s.hit) begin
              cls_s   = lut_s.cls;
              opc_s   = lut_s.opc;
              fn_s    = lut_s.fn;
              state_s = ST_OPS;
            end else begin
              bad_s = 1'b1;
            end
          end else if (ch_s == CH_LF) begin
            if (mlen_r == 3'd0) begin
              state_s = ST_MNEM;            // blank line, nothing emitted
            end else if (!lut_s.hit || (cls_count(lut_s.cls) != 2'd0)) begin
              bad_s = 1'b1;
            end else begin
              done_s  = 1'b1;
              instr_s = encode(lut_s.cls, lut_s.opc, lut_s.fn, 5'd0, 16'd0, 16'd0);
            end
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          state_s = ST_MNEM;
        end
      end
      ST_OPS: begin
        if (accept_s && (ch_s != CH_CR) && (ch_s != CH_SP)) begin
          if (ch_s == CH_LF) begin
            if ((idx_r == 2'd0) && (ocnt_r == 3'd0) && !odol_r) begin
              // No operand text at all after the mnemonic.
              if (cnt_s != 2'd0) begin
                bad_s = 1'b1;
              end else begin
                done_s  = 1'b1;
                instr_s = encode(cls_r, opc_r, fn_r, 5'd0, 16'd0, 16'd0);
              end
            end else if ((ocnt_r == 3'd0) || ((idx_r + 2'd1) != cnt_s)) begin
              bad_s = 1'b1;
            end else begin
              op0_s   = st0_s;
              op1_s   = st1_s;
              op2_s   = st2_s;
              done_s  = 1'b1;
              instr_s = encode(cls_r, opc_r, fn_r, st0_s, st1_s, st2_s);
            end
          end else if (cnt_s == 2'd0) begin
            bad_s = 1'b1;
          end else if (ch_s == CH_COMMA) begin
            // Too many operands is caught here rather than waiting for LF.
            if ((ocnt_r == 3'd0) || ((idx_r + 2'd1) >= cnt_s)) begin
              bad_s = 1'b1;
            end else begin
              op0_s  = st0_s;
              op1_s  = st1_s;
              op2_s  = st2_s;
              idx_s  = idx_r + 2'd1;
              opv_s  = 16'd0;
              ocnt_s = 3'd0;
              odol_s = 1'b0;
            end
          end else if (ch_s == CH_DOLLAR) begin
            if (slot_imm_s || odol_r || (ocnt_r != 3'd0)) begin
              bad_s = 1'b1;
            end else begin
              odol_s = 1'b1;
            end
          end else if (is_digit_s || is_hexl_s) begin
            if (slot_imm_s) begin
              if (ocnt_r == 3'd4) begin
                bad_s = 1'b1;
              end else begin
                opv_s  = {opv_r[11:0], nib_s};
                ocnt_s = ocnt_r + 3'd1;
              end
            end else if (is_hexl_s || (reg_val_s > 16'd31)) begin
              bad_s = 1'b1;
            end else begin
              opv_s  = reg_val_s;
              ocnt_s = 3'd1;
            end
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          state_s = ST_OPS;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_s = ST_MNEM;
          acc_s   = 40'd0;
          mlen_s  = 3'd0;
          opv_s   = 16'd0;
          ocnt_s  = 3'd0;
          odol_s  = 1'b0;
          idx_s   = 2'd0;
          op0_s   = 5'd0;
          op1_s   = 16'd0;
          op2_s   = 16'd0;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DRAIN: begin
        // The terminating LF takes the common error exit below.
        if (accept_s && (ch_s == CH_LF)) begin
          bad_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_MNEM;
      end
    endcase

    if (bad_s) begin
      if (ch_s == CH_LF) begin
        state_s = ST_EMIT;
        err_s   = 1'b1;
        instr_s = 32'd0;
      end else begin
        state_s = ST_DRAIN;
      end
    end else if (done_s) begin
      state_s = ST_EMIT;
      err_s   = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // Parser state and accumulators.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_MNEM;
      acc_r   <= 40'd0;
      mlen_r  <= 3'd0;
      cls_r   <= CLS_NOP;
      opc_r   <= 6'd0;
      fn_r    <= 6'd0;
      opv_r   <= 16'd0;
      ocnt_r  <= 3'd0;
      odol_r  <= 1'b0;
      idx_r   <= 2'd0;
      op0_r   <= 5'd0;
      op1_r   <= 16'd0;
      op2_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      mlen_r  <= mlen_s;
      cls_r   <= cls_s;
      opc_r   <= opc_s;
      fn_r    <= fn_s;
      opv_r   <= opv_s;
      ocnt_r  <= ocnt_s;
      odol_r  <= odol_s;
      idx_r   <= idx_s;
      op0_r   <= op0_s;
      op1_r   <= op1_s;
      op2_r   <= op2_s;
    end
  end

  // Output registers; handshake flags are derived from the next state so they align with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instr_r     <= 32'd0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      instr_r     <= instr_s;
      err_r       <= err_s;
      out_valid_r <= (state_s == ST_EMIT);
      in_ready_r  <= (state_s != ST_EMIT);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign instr     = instr_r;
  assign err       = err_r;

endmodule
